alu_sequencer: RTL and testbench

//  Front-panel controller that sequences the 8-bit ALU from one step button.
//  It loads operand A, then operand B, then issues the chosen operation.
//  It captures Y into a held result register for the seven-segment path.
//  It sits between the board inputs (sw, step button) and the ALU data/select/perform pins.

---
 rtl/alu_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-panel controller that walks an 8-bit ALU through
// load A, load B and execute from a single debounced step button, and holds
// the captured ALU result for the seven-segment display path.

// Button front end: 2-FF synchronizer, stable-level debouncer and a
// one-cycle event on each accepted 0->1 transition of the debounced level.
module alu_sequencer_debounce #(
    parameter int unsigned CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise_ev
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer shift and candidate-level counter.
    always_comb begin
        sync_d  = {sync_q[0], btn};
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_ev = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            // The new level has now been seen for CYCLES consecutive clocks.
            level_d = sync_q[1];
            cnt_d   = '0;
            rise_ev = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

module alu_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ALU_LATENCY     = 1,
    parameter logic [3:0]  OP_LOAD_A       = 4'hE,
    parameter logic [3:0]  OP_LOAD_B       = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_step,
    input  logic       btn_clear,
    input  logic [7:0] sw_data,
    input  logic [3:0] sw_op,
    output logic [7:0] alu_data,
    output logic [3:0] alu_select,
    output logic       alu_perform,
    input  logic [7:0] alu_y,
    output logic [7:0] result,
    output logic [2:0] phase,
    output logic       done
);

    localparam int unsigned LW = $clog2(ALU_LATENCY + 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(ALU_LATENCY);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_e;

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          rst_n;
    logic          step_ev;
    logic          clear_ev;

    state_e        state_q, state_d;
    logic [7:0]    alu_data_q, alu_data_d;
    logic [3:0]    alu_select_q, alu_select_d;
    logic          alu_perform_q, alu_perform_d;
    logic [7:0]    result_q, result_d;
    logic          done_q, done_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;

    // Reset synchronizer: assertion takes effect immediately, release is
    // aligned to clk so no flop sees reset removal near an edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    alu_sequencer_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_step),
        .rise_ev (step_ev)
    );

    alu_sequencer_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn_clear),
        .rise_ev (clear_ev)
    );

    // Next-state and command logic; clear takes priority over any step.
    always_comb begin
        state_d       = state_q;
        alu_data_d    = alu_data_q;
        alu_select_d  = alu_select_q;
        alu_perform_d = 1'b0;
        result_d      = result_q;
        done_d        = done_q;
        lat_cnt_d     = lat_cnt_q;

        if (clear_ev) begin
            state_d  = WAIT_A;
            done_d   = 1'b0;
            result_d = '0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (step_ev) begin
                        alu_data_d    = sw_data;
                        alu_select_d  = OP_LOAD_A;
                        alu_perform_d = 1'b1;
                        state_d       = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (step_ev) begin
                        alu_data_d    = sw_data;
                        alu_select_d  = OP_LOAD_B;
                        alu_perform_d = 1'b1;
                        state_d       = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (step_ev) begin
                        alu_select_d  = sw_op;
                        alu_perform_d = 1'b1;
                        lat_cnt_d     = LAT_LOAD;
                        state_d       = EXEC;
                    end
                end
                EXEC: begin
                    // Counter is ALU_LATENCY in the perform cycle, so the
                    // zero cycle is exactly ALU_LATENCY cycles later.
                    if (lat_cnt_q == '0) begin
                        result_d = alu_y;
                        done_d   = 1'b1;
                        state_d  = SHOW;
                    end else begin
                        lat_cnt_d = lat_cnt_q - LW'(1);
                    end
                end
                SHOW: begin
                    if (step_ev) begin
                        done_d  = 1'b0;
                        state_d = WAIT_A;
                    end
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_A;
            alu_data_q    <= '0;
            alu_select_q  <= '0;
            alu_perform_q <= 1'b0;
            result_q      <= '0;
            done_q        <= 1'b0;
            lat_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            alu_data_q    <= alu_data_d;
            alu_select_q  <= alu_select_d;
            alu_perform_q <= alu_perform_d;
            result_q      <= result_d;
            done_q        <= done_d;
            lat_cnt_q     <= lat_cnt_d;
        end
    end

    assign alu_data    = alu_data_q;
    assign alu_select  = alu_select_q;
    assign alu_perform = alu_perform_q;
    assign result      = result_q;
    assign phase       = state_q;
    assign done        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized stepping of alu_sequencer against a
// transaction-level model, with an ALU stand-in that only presents a valid
// result in the exact latency cycle.
module tb_alu_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned LAT = 3;
    localparam logic [3:0]  OPA = 4'hE;
    localparam logic [3:0]  OPB = 4'hF;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_step, btn_clear;
    logic [7:0] sw_data;
    logic [3:0] sw_op;
    logic [7:0] alu_data;
    logic [3:0] alu_select;
    logic       alu_perform;
    logic [7:0] alu_y = 8'h00;
    logic [7:0] result;
    logic [2:0] phase;
    logic       done;

    // second instance: fast debounce, long latency (step-during-EXEC case)
    logic       x_reset, x_step, x_clear;
    logic [7:0] x_sw_data;
    logic [3:0] x_sw_op;
    logic [7:0] x_alu_data;
    logic [3:0] x_alu_select;
    logic       x_perform;
    logic [7:0] x_alu_y;
    logic [7:0] x_result;
    logic [2:0] x_phase;
    logic       x_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .ALU_LATENCY     (LAT),
        .OP_LOAD_A       (OPA),
        .OP_LOAD_B       (OPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_step    (btn_step),
        .btn_clear   (btn_clear),
        .sw_data     (sw_data),
        .sw_op       (sw_op),
        .alu_data    (alu_data),
        .alu_select  (alu_select),
        .alu_perform (alu_perform),
        .alu_y       (alu_y),
        .result      (result),
        .phase       (phase),
        .done        (done)
    );

    alu_sequencer #(
        .DEBOUNCE_CYCLES (1),
        .ALU_LATENCY     (8),
        .OP_LOAD_A       (OPA),
        .OP_LOAD_B       (OPB)
    ) dut_x (
        .clk         (clk),
        .reset       (x_reset),
        .btn_step    (x_step),
        .btn_clear   (x_clear),
        .sw_data     (x_sw_data),
        .sw_op       (x_sw_op),
        .alu_data    (x_alu_data),
        .alu_select  (x_alu_select),
        .alu_perform (x_perform),
        .alu_y       (x_alu_y),
        .result      (x_result),
        .phase       (x_phase),
        .done        (x_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return ~a;
            4'h6:    return a << 1;
            4'h7:    return b >> 1;
            default: return a + b + {4'h0, op};
        endcase
    endfunction

    // ---------------- transaction-level model ----------------
    int unsigned m_phase  = 0;
    logic [7:0]  m_result = 8'h00;
    logic        m_done   = 1'b0;
    logic [7:0]  m_data   = 8'h00;
    logic [7:0]  m_a = 8'h00, m_b = 8'h00;
    logic [11:0] exp_q[$];
    int unsigned exp_count = 0;

    // ---------------- ALU stand-in / perform monitor ----------------
    int unsigned cyc = 0;
    int unsigned fire = 0;
    int unsigned perf_count = 0;
    bit          prev_perf = 1'b0;
    bit          exec_pending = 1'b0;
    logic [7:0]  alu_a = 8'h00, alu_b = 8'h00, pend = 8'h00;

    always @(negedge clk) begin
        logic [11:0] e;
        cyc++;
        if (alu_perform) begin
            perf_count++;
            check("perform_one_cycle", prev_perf, 0);
            check("perform_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("perform_select", alu_select, e[11:8]);
                check("perform_data", alu_data, e[7:0]);
            end
            if (alu_select == OPA) alu_a = alu_data;
            else if (alu_select == OPB) alu_b = alu_data;
            else begin
                pend = alu_fn(alu_select, alu_a, alu_b);
                fire = cyc + LAT;
                exec_pending = 1'b1;
            end
        end
        prev_perf = alu_perform;
        if (exec_pending && cyc == fire) begin
            check("result_not_early", result, m_result);
        end else if (exec_pending && cyc == fire + 1) begin
            check("result_at_latency", result, pend);
            check("done_at_latency", done, 1);
            exec_pending = 1'b0;
        end
        alu_y = (exec_pending && cyc == fire) ? pend : ~pend;
    end

    int unsigned x_perf = 0;
    always @(negedge clk) begin
        if (x_perform) x_perf++;
    end

    task automatic press(input bit s, input bit c, input int unsigned hold);
        @(negedge clk);
        btn_step  = s;
        btn_clear = c;
        repeat (hold) @(negedge clk);
        btn_step  = 1'b0;
        btn_clear = 1'b0;
        // switches wander while no step event is possible
        repeat (12) begin
            @(negedge clk);
            sw_data = 8'($urandom);
            sw_op   = 4'($urandom);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_phase"}, phase, m_phase);
        check({tag, "_done"}, done, m_done);
        check({tag, "_result"}, result, m_result);
        check({tag, "_perf_count"}, perf_count, exp_count);
    endtask

    task automatic do_step(input logic [7:0] d, input logic [3:0] op, input int unsigned hold);
        logic [7:0] nxt_result;
        nxt_result = m_result;
        @(negedge clk);
        sw_data = d;
        sw_op   = op;
        case (m_phase)
            0: begin exp_q.push_back({OPA, d}); exp_count++; m_data = d; m_a = d; m_phase = 1; end
            1: begin exp_q.push_back({OPB, d}); exp_count++; m_data = d; m_b = d; m_phase = 2; end
            2: begin exp_q.push_back({op, m_data}); exp_count++; nxt_result = alu_fn(op, m_a, m_b); m_phase = 4; end
            default: begin m_phase = 0; end
        endcase
        press(1'b1, 1'b0, hold);
        m_result = nxt_result;
        m_done   = (m_phase == 4);
        check_state("step");
    endtask

    task automatic do_clear(input bit with_step);
        press(with_step, 1'b1, 10);
        m_phase  = 0;
        m_done   = 1'b0;
        m_result = 8'h00;
        check_state(with_step ? "clear_and_step" : "clear");
    endtask

    task automatic do_glitch();
        press(1'b1, 1'b0, 3);
        check_state("glitch");
    endtask

    task automatic x_press();
        @(negedge clk);
        x_step = 1'b1;
        @(negedge clk);
        x_step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; x_reset = 1'b1;
        btn_step = 1'b0; btn_clear = 1'b0; sw_data = 8'h00; sw_op = 4'h0;
        x_step = 1'b0; x_clear = 1'b0; x_sw_data = 8'h00; x_sw_op = 4'h0; x_alu_y = 8'h5A;
        #1;
        reset = 1'b0; x_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_alu_data", alu_data, 0);
        check("rst_alu_select", alu_select, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_state("post_reset");

        // directed: 12 + 05 with op 0
        do_step(8'h12, 4'h0, 10);
        do_step(8'h05, 4'h0, 10);
        do_step(8'hC3, 4'h0, 10);
        check("directed_result", result, 8'h17);

        // glitch shorter than the debounce window, then a 5-cycle press
        do_glitch();
        do_step(8'h00, 4'h0, 5);

        // clear and step together from WAIT_OP
        do_step(8'h40, 4'h0, 10);
        do_step(8'h21, 4'h0, 10);
        do_clear(1'b1);

        for (int i = 0; i < 40; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0) do_clear(1'b0);
            else if (r == 1) do_clear(1'b1);
            else if (r == 2) do_glitch();
            else do_step(8'($urandom), 4'($urandom_range(0, 13)), 10);
        end
        check("queue_drained", exp_q.size(), 0);

        // step during EXEC is ignored, then reset while in SHOW
        x_reset = 1'b1;
        repeat (4) @(negedge clk);
        x_sw_data = 8'h33;
        x_sw_op   = 4'h2;
        x_press();
        x_press();
        x_press();
        x_press();
        check("x_exec_phase", x_phase, 3);
        check("x_exec_perf", x_perf, 3);
        repeat (12) @(negedge clk);
        check("x_show_phase", x_phase, 4);
        check("x_show_done", x_done, 1);
        check("x_show_result", x_result, 8'h5A);
        check("x_show_perf", x_perf, 3);
        x_reset = 1'b0;
        @(negedge clk);
        check("x_rst_phase", x_phase, 0);
        check("x_rst_done", x_done, 0);
        check("x_rst_result", x_result, 0);
        check("x_rst_alu_data", x_alu_data, 0);
        check("x_rst_alu_select", x_alu_select, 0);
        check("x_rst_perform", x_perform, 0);
        x_reset = 1'b1;
        repeat (4) @(negedge clk);
        check("x_post_rst_phase", x_phase, 0);
        check("x_post_rst_result", x_result, 0);
        check("x_post_rst_perf", x_perf, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
